// File: rtl/if_id_skid_pipe_pkg.sv
// Shared types and helpers for the IF->ID skid pipeline register.
// Occupancy states and the default field widths used at the fetch/decode boundary.
package if_id_skid_pipe_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefInstW = 32;
  localparam int unsigned DefCntW  = 16;

  // Encoding equals the number of entries held.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } skid_state_e;

  function automatic logic [1:0] held_count(skid_state_e st);
    case (st)
      StOne:   held_count = 2'd1;
      StTwo:   held_count = 2'd2;
      default: held_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/if_id_skid_pipe_if.sv
// Fetch->decode handshake bundle: upstream valid/ready payload, downstream payload,
// redirect flush and the flush-drop statistic.
interface if_id_skid_pipe_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic              flush;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output in_valid, in_pc, in_inst, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_inst, drop_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready, flush,
    output in_ready, out_valid, out_pc, out_inst, drop_cnt
  );

endinterface

// File: rtl/if_id_skid_pipe.sv
// IF/ID boundary register with a 2-entry skid buffer, valid/ready handshake, flush
// and a saturating count of entries discarded by flush. in_ready is fully registered.
module if_id_skid_pipe
  import if_id_skid_pipe_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DefAddrW,
  parameter int unsigned       INST_W   = DefInstW,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter int unsigned       CNT_W    = DefCntW
) (
  input logic              clk,
  input logic              rst,
  if_id_skid_pipe_if.slave bus
);

  skid_state_e       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] main_pc_q, skid_pc_q;
  logic [INST_W-1:0] main_inst_q, skid_inst_q;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W:0]    drop_sum;
  logic [1:0]        drop_inc;
  logic              out_valid, accept, emit;
  logic              load_main, load_skid, main_from_skid;

  assign out_valid = (state_q != StEmpty);
  assign accept    = bus.in_valid & in_ready_q;
  assign emit      = out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    drop_inc       = 2'd0;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = StOne;
        end
      end
      StOne: begin
        if (accept && emit) begin
          load_main = 1'b1;
        end else if (emit) begin
          state_d = StEmpty;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = StTwo;
        end
      end
      StTwo: begin
        if (emit) begin
          main_from_skid = 1'b1;
          state_d        = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // A same-cycle emit already reached decode, so it is not counted as dropped;
    // main is left untouched so out_pc keeps its last value.
    if (bus.flush) begin
      state_d        = StEmpty;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      drop_inc       = held_count(state_q) - {1'b0, emit};
    end
    in_ready_d = (state_d != StTwo);
  end

  assign drop_sum   = {1'b0, drop_cnt_q} + (CNT_W + 1)'(drop_inc);
  assign drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
      drop_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      drop_cnt_q <= drop_cnt_d;
      if (load_main) begin
        main_pc_q   <= bus.in_pc;
        main_inst_q <= bus.in_inst;
      end else if (main_from_skid) begin
        main_pc_q   <= skid_pc_q;
        main_inst_q <= skid_inst_q;
      end
      if (load_skid) begin
        skid_pc_q   <= bus.in_pc;
        skid_inst_q <= bus.in_inst;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = main_pc_q;
  assign bus.out_inst  = out_valid ? main_inst_q : NOP_INST;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_if_id_skid_pipe.sv
// Scoreboard bench for if_id_skid_pipe: directed handshake/flush steps followed by
// random valid/ready/flush traffic, with a 2-bit drop counter to reach saturation.
module tb_if_id_skid_pipe;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;
  localparam int unsigned CW = 2;
  localparam logic [IW-1:0] Nop = 32'h0;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_id_skid_pipe_if #(.ADDR_W(AW), .INST_W(IW), .CNT_W(CW)) bus ();

  if_id_skid_pipe #(
    .ADDR_W  (AW),
    .INST_W  (IW),
    .NOP_INST(Nop),
    .CNT_W   (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ent_t          sb[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  int            exp_drop = 0;
  logic [AW-1:0] last_pc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] pc, input logic ordy,
                       input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_inst   = {pc[15:0], ~pc[15:0]};
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  // One clock: update the model from the pre-edge handshake, then check every output.
  task automatic cycle();
    int   held;
    logic emit, acc;
    ent_t e;
    held = sb.size();
    emit = bus.out_valid && bus.out_ready;
    acc  = bus.in_valid && bus.in_ready;
    if (emit) begin
      if (sb.size() == 0) check("emit_with_empty_model", 32'(emit), 32'h0);
      else void'(sb.pop_front());
    end
    if (bus.flush) begin
      exp_drop += held - int'(emit);
      if (exp_drop > (1 << CW) - 1) exp_drop = (1 << CW) - 1;
      sb.delete();
    end else if (acc) begin
      e.pc   = bus.in_pc;
      e.inst = bus.in_inst;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) last_pc = sb[0].pc;
    check("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
    check("in_ready", 32'(bus.in_ready), 32'(sb.size() < 2));
    check("out_pc", bus.out_pc, last_pc);
    check("out_inst", bus.out_inst, (sb.size() > 0) ? sb[0].inst : Nop);
    check("drop_cnt", 32'(bus.drop_cnt), 32'(exp_drop));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_drop = 0;
    last_pc  = '0;
  endtask

  initial begin
    // Reset held 3 cycles with in_valid high.
    do_reset(3);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_out_pc", bus.out_pc, 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);

    // Streaming 0x0,0x4,0x8 with decode always ready: 1-cycle latency, no bubbles.
    drive(1'b1, 32'h0, 1'b1, 1'b0); cycle();
    check("stream_pc0", bus.out_pc, 32'h0);
    drive(1'b1, 32'h4, 1'b1, 1'b0); cycle();
    check("stream_pc4", bus.out_pc, 32'h4);
    drive(1'b1, 32'h8, 1'b1, 1'b0); cycle();
    check("stream_pc8", bus.out_pc, 32'h8);
    check("stream_valid", 32'(bus.out_valid), 32'h1);
    drive(1'b0, 32'h0, 1'b1, 1'b0); cycle();

    // Back-pressure: 0x10 held, 0x14 goes to skid, 0x18 refused while full.
    drive(1'b1, 32'h10, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h14, 1'b0, 1'b0); cycle();
    check("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
    drive(1'b1, 32'h18, 1'b0, 1'b0); cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0); cycle();
    check("bp_release_first", bus.out_pc, 32'h14);
    cycle();
    check("bp_drained", 32'(bus.out_valid), 32'h0);

    // Flush from TWO without emit drops both entries.
    drive(1'b1, 32'h20, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h24, 1'b0, 1'b0); cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1); cycle();
    check("flush2_drop", 32'(bus.drop_cnt), 32'h2);
    check("flush2_in_ready", 32'(bus.in_ready), 32'h1);
    check("flush2_out_valid", 32'(bus.out_valid), 32'h0);

    // Flush in ONE with same-cycle emit and accept: nothing counted, input discarded.
    drive(1'b1, 32'h30, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h34, 1'b1, 1'b1); cycle();
    check("flush1_drop_same", 32'(bus.drop_cnt), 32'h2);
    drive(1'b0, 32'h0, 1'b1, 1'b0); cycle();
    check("flush1_discarded", 32'(bus.out_valid), 32'h0);

    // Saturation of the 2-bit counter: 2, 3, 3.
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h40 + 32'(8 * k), 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h44 + 32'(8 * k), 1'b0, 1'b0); cycle();
      drive(1'b0, 32'h0, 1'b0, 1'b1); cycle();
    end
    check("sat_drop", 32'(bus.drop_cnt), 32'h3);

    // Random traffic against the scoreboard.
    do_reset(1);
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 32'h1000 + 32'(4 * k),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) cycle();
    check("final_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
